mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning BUSY cycles without ack before timeout (range 1..255).
REQ-002 SHALL have port in_CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_CLR_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_memread / in_memwrite  input  1  load / store request from the EX/MEM register.
REQ-005 SHALL have ports in_size  input  2  00 byte, 01 half, 10 word, 11 treated as word; in_unsigned  input  1  zero-extend loads.
REQ-006 SHALL have ports in_R  input  32  effective address (ALU result); in_rb  input  32  store data.
REQ-007 SHALL have ports out_mem_req / out_mem_we  output  1  bus request / write strobe; out_mem_addr  output  32  word address, bits [1:0] = 0.
REQ-008 SHALL have ports out_mem_wdata  output  32  lane-aligned store data; out_mem_be  output  4  byte enables; in_mem_ack  input  1  bus completion; in_mem_rdata  input  32  read data, valid with ack.
REQ-009 SHALL have ports out_Memdata  output  32  formatted load data for MEM/WB; out_stall  output  1  pipeline hold (drives pipeline-register in_EN low); out_fault  output  1  misaligned or timed-out access.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 SHALL define access = in_memread | in_memwrite; both high is a store.
REQ-012 SHALL detect misalign = (half & in_R[0]) | (word & in_R[1:0] != 0).
REQ-013 IDLE: access & !misalign -> BUSY; register addr, we, wdata, be; out_stall = 1 combinationally in that cycle.
REQ-014 IDLE: access & misalign -> no bus request, stay IDLE; out_fault = 1 and out_stall = 0 combinationally; out_Memdata unchanged.
REQ-015 BUSY: out_mem_req = 1 with addr/we/wdata/be stable; out_stall = 1; in_mem_ack = 1 -> DONE, capturing formatted rdata into out_Memdata on loads.
REQ-016 DONE: out_stall = 0 and out_mem_req = 0 for exactly one cycle; always -> IDLE next cycle. Minimum access = 3 cycles (2 stalled).
REQ-017 in_mem_ack SHALL be ignored outside BUSY.
REQ-018 Store formatting: byte -> data[7:0] replicated to all lanes, be = 1 << in_R[1:0]; half -> data[15:0] replicated, be = 0011 (in_R[1] = 0) or 1100; word -> be = 1111.
REQ-019 Load formatting: byte lane in_R[1:0], half lane in_R[1]; sign-extend unless in_unsigned; word unchanged.
REQ-020 Stores SHALL leave out_Memdata unchanged.

Reset
REQ-021 in_CLR_N low SHALL immediately force state IDLE, out_mem_req = 0, out_mem_we = 0, out_mem_addr = 0, out_mem_wdata = 0, out_mem_be = 0, out_Memdata = 0, out_fault = 0, timeout counter = 0.
REQ-022 Reset asserted in BUSY SHALL abandon the access; a late ack after release SHALL be ignored.

Configuration
REQ-023 Macro MEM_TIMEOUT_EN defined: an 8-bit counter clears on IDLE->BUSY and increments each BUSY cycle without ack; on reaching TIMEOUT_CYC go BUSY->DONE, out_Memdata = 0, out_fault = 1 during DONE only; ack in the same cycle as the limit wins (normal completion, no fault).
REQ-024 Macro undefined: no counter; BUSY waits indefinitely for ack; out_fault arises only from misalignment.

Verification
REQ-025 Word load, in_R = 0x100, ack in 1st BUSY cycle, rdata 0xDEADBEEF -> req 1 cycle, out_stall 1 for 2 cycles, out_Memdata = 0xDEADBEEF in DONE.
REQ-026 Signed byte load in_R = 0x103, rdata 0x80112233 -> out_Memdata = 0xFFFFFF80; with in_unsigned -> 0x00000080.
REQ-027 Half store in_R = 0x202, in_rb = 0x1234ABCD, ack after 3 BUSY cycles -> addr 0x200, be = 1100, wdata = 0xABCDABCD held 3 cycles, we = 1.
REQ-028 Word load in_R = 0x101 -> out_fault = 1, out_stall = 0, out_mem_req never asserts.
REQ-029 MEM_TIMEOUT_EN, TIMEOUT_CYC = 4, no ack -> req for 4 cycles, DONE with out_fault = 1, out_Memdata = 0; without macro, stall persists 300 cycles until ack.
REQ-030 in_CLR_N pulsed low in BUSY -> out_mem_req = 0 asynchronously, state IDLE, ack 2 cycles after release ignored.

Source files
------------

// File: rtl/mem_access_if.sv
// Bundle of the pipeline-side request/response signals and the memory-bus signals used by
// mem_access. The master modport is the memory-access stage; slave is its environment.
interface mem_access_if;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_R;
  logic [31:0] in_rb;

  logic        out_mem_req;
  logic        out_mem_we;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [3:0]  out_mem_be;
  logic        in_mem_ack;
  logic [31:0] in_mem_rdata;

  logic [31:0] out_Memdata;
  logic        out_stall;
  logic        out_fault;

  modport master (
    input  in_memread, in_memwrite, in_size, in_unsigned, in_R, in_rb, in_mem_ack, in_mem_rdata,
    output out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_be, out_Memdata,
    output out_stall, out_fault
  );

  modport slave (
    output in_memread, in_memwrite, in_size, in_unsigned, in_R, in_rb, in_mem_ack, in_mem_rdata,
    input  out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_be, out_Memdata,
    input  out_stall, out_fault
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: issues one bus transaction per load/store and stalls the pipeline
// until it completes. Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC unacked cycles.
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic          in_CLK,
  input logic          in_CLR_N,
  mem_access_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic        req_q, we_q, load_q, uns_q, fault_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] addr_q, wdata_q, mdata_q;
  logic [3:0]  be_q;

  logic        access, is_half, is_word, misalign, start, timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   fmt_load = {{24{b[7] & ~uns}}, b};
      2'b01:   fmt_load = {{16{h[15] & ~uns}}, h};
      default: fmt_load = rdata;
    endcase
  endfunction

  always_comb begin
    access   = bus_io.in_memread | bus_io.in_memwrite;
    is_half  = bus_io.in_size == 2'b01;
    is_word  = bus_io.in_size[1];
    misalign = (is_half & bus_io.in_R[0]) | (is_word & (bus_io.in_R[1:0] != 2'b00));
    start    = (state_q == StIdle) & access & ~misalign;
  end

  always_comb begin
    st_wdata = bus_io.in_rb;
    st_be    = 4'b1111;
    case (bus_io.in_size)
      2'b00: begin
        st_wdata = {4{bus_io.in_rb[7:0]}};
        st_be    = 4'b0001 << bus_io.in_R[1:0];
      end
      2'b01: begin
        st_wdata = {2{bus_io.in_rb[15:0]}};
        st_be    = bus_io.in_R[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;

  assign timeout = (cnt_q + 8'd1) == 8'(TIMEOUT_CYC);

  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      cnt_q <= 8'd0;
    end else if (start) begin
      cnt_q <= 8'd0;
    end else if (state_q == StBusy && !bus_io.in_mem_ack) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  logic unused_cfg;
  assign timeout    = 1'b0;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge in_CLK or negedge in_CLR_N) begin
    if (!in_CLR_N) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            req_q   <= 1'b1;
            we_q    <= bus_io.in_memwrite;
            load_q  <= ~bus_io.in_memwrite;
            uns_q   <= bus_io.in_unsigned;
            size_q  <= bus_io.in_size;
            lane_q  <= bus_io.in_R[1:0];
            addr_q  <= {bus_io.in_R[31:2], 2'b00};
            wdata_q <= st_wdata;
            be_q    <= st_be;
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (bus_io.in_mem_ack) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            if (load_q) mdata_q <= fmt_load(bus_io.in_mem_rdata, size_q, lane_q, uns_q);
          end else if (timeout) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mdata_q <= 32'd0;
            fault_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          fault_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.out_mem_req   = req_q;
  assign bus_io.out_mem_we    = we_q;
  assign bus_io.out_mem_addr  = addr_q;
  assign bus_io.out_mem_wdata = wdata_q;
  assign bus_io.out_mem_be    = be_q;
  assign bus_io.out_Memdata   = mdata_q;
  assign bus_io.out_stall     = start | (state_q == StBusy);
  assign bus_io.out_fault     = fault_q |
                                ((state_q == StIdle) & access & misalign & in_CLR_N);

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random loads/stores checked
// against a byte-arithmetic model of the bus and load formatting.
module tb_mem_access;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TCYC = 4;
`else
  localparam int unsigned TCYC = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  logic [31:0] exp_mdata = 32'd0;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYC(TCYC)) dut (
    .in_CLK  (clk),
    .in_CLR_N(rst_n),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.in_memread  = 1'b0;
    bus.in_memwrite = 1'b0;
  endtask

  // One access from the pipeline's view; delay = BUSY cycles before the acked one.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] r, input logic [31:0] rb,
                            input int delay, input logic [31:0] rdata);
    int nb, off;
    bit mis, is_load;
    logic [31:0] e_be, e_wd, e_ld, sh, mask;
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off     = int'(r[1:0]);
    mis     = (off % nb) != 0;
    is_load = rd && !wr;
    e_be    = ((32'd1 << nb) - 32'd1) << off;
    e_wd    = (nb == 1) ? rb[7:0] * 32'h01010101 : (nb == 2) ? rb[15:0] * 32'h00010001 : rb;
    sh      = rdata >> (8 * off);
    if (nb == 4) e_ld = rdata;
    else begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      e_ld = sh & mask;
      if (!uns && sh[8*nb-1]) e_ld = e_ld | ~mask;
    end

    @(negedge clk);
    bus.in_memread  = rd;
    bus.in_memwrite = wr;
    bus.in_size     = sz;
    bus.in_unsigned = uns;
    bus.in_R        = r;
    bus.in_rb       = rb;
    #1;
    chk("idle_stall", bus.out_stall, !mis);
    chk("idle_fault", bus.out_fault, mis);
    chk("idle_req", bus.out_mem_req, 0);
    if (mis) begin
      @(posedge clk); #1;
      chk("mis_req", bus.out_mem_req, 0);
      chk("mis_mdata", bus.out_Memdata, exp_mdata);
      idle_inputs();
      return;
    end

    for (int c = 0; c <= delay; c++) begin
      @(posedge clk); #1;
      chk("busy_req", bus.out_mem_req, 1);
      chk("busy_we", bus.out_mem_we, wr);
      chk("busy_addr", bus.out_mem_addr, {r[31:2], 2'b00});
      chk("busy_be", bus.out_mem_be, e_be);
      chk("busy_wdata", bus.out_mem_wdata, e_wd);
      chk("busy_stall", bus.out_stall, 1);
      bus.in_mem_ack   = (c == delay);
      bus.in_mem_rdata = (c == delay) ? rdata : $urandom;
    end

    @(posedge clk); #1;
    if (is_load) exp_mdata = e_ld;
    chk("done_req", bus.out_mem_req, 0);
    chk("done_stall", bus.out_stall, 0);
    chk("done_fault", bus.out_fault, 0);
    chk("done_mdata", bus.out_Memdata, exp_mdata);
    // Stray ack in DONE must be ignored.
    bus.in_mem_ack   = 1'b1;
    bus.in_mem_rdata = $urandom;
    idle_inputs();
    @(posedge clk); #1;
    chk("post_req", bus.out_mem_req, 0);
    chk("post_stall", bus.out_stall, 0);
    chk("post_mdata", bus.out_Memdata, exp_mdata);
    bus.in_mem_ack = 1'b0;
  endtask

  initial begin
    logic       rd, wr, uns;
    logic [1:0] sz;
    logic [31:0] r;
    int k;

    idle_inputs();
    bus.in_size      = 2'b00;
    bus.in_unsigned  = 1'b0;
    bus.in_R         = 32'd0;
    bus.in_rb        = 32'd0;
    bus.in_mem_ack   = 1'b0;
    bus.in_mem_rdata = 32'd0;
    #2;
    chk("rst_req", bus.out_mem_req, 0);
    chk("rst_we", bus.out_mem_we, 0);
    chk("rst_addr", bus.out_mem_addr, 0);
    chk("rst_wdata", bus.out_mem_wdata, 0);
    chk("rst_be", bus.out_mem_be, 0);
    chk("rst_mdata", bus.out_Memdata, 0);
    chk("rst_fault", bus.out_fault, 0);
    chk("rst_stall", bus.out_stall, 0);
    #10 rst_n = 1'b1;

    run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80112233);
    chk("sbyte_val", bus.out_Memdata, 32'hFFFFFF80);
    run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80112233);
    chk("ubyte_val", bus.out_Memdata, 32'h00000080);
    run_access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 2, 32'h0);
    run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0);
    run_access(1, 1, 2'b00, 0, 32'h301, 32'h000000A5, 0, 32'h0);
    run_access(1, 0, 2'b11, 1, 32'h404, 32'h0, 1, 32'h01020304);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    bus.in_memread = 1'b1;
    bus.in_size    = 2'b10;
    bus.in_R       = 32'h500;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("to_req", bus.out_mem_req, 1);
    end
    idle_inputs();
    @(posedge clk); #1;
    exp_mdata = 32'd0;
    chk("to_done_req", bus.out_mem_req, 0);
    chk("to_fault", bus.out_fault, 1);
    chk("to_mdata", bus.out_Memdata, 0);
    chk("to_stall", bus.out_stall, 0);
    @(posedge clk); #1;
    chk("to_fault_clr", bus.out_fault, 0);
`else
    run_access(1, 0, 2'b10, 0, 32'h500, 32'h0, 299, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 2);
      rd  = (k != 1);
      wr  = (k != 0);
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      r   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) r[0] = 1'b0;
        else if (sz[1]) r[1:0] = 2'b00;
      end
      run_access(rd, wr, sz, uns, r, $urandom, $urandom_range(0, 3), $urandom);
    end

    // Reset in BUSY abandons the access; a late ack must not revive it.
    @(negedge clk);
    bus.in_memread = 1'b1;
    bus.in_size    = 2'b10;
    bus.in_R       = 32'h600;
    @(posedge clk); #1;
    chk("rb_req", bus.out_mem_req, 1);
    rst_n = 1'b0;
    #1;
    exp_mdata = 32'd0;
    chk("rb_req_async", bus.out_mem_req, 0);
    chk("rb_mdata", bus.out_Memdata, 0);
    chk("rb_be", bus.out_mem_be, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    bus.in_mem_ack   = 1'b1;
    bus.in_mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.in_mem_ack = 1'b0;
    chk("late_req", bus.out_mem_req, 0);
    chk("late_stall", bus.out_stall, 0);
    chk("late_mdata", bus.out_Memdata, 0);
    run_access(1, 0, 2'b01, 0, 32'h702, 32'h0, 0, 32'h9ABC1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
